// File: rtl/mem_ctrl.sv
// Single-request memory controller: latches a client op, waits out the memory busy handshake, then pulses done.
// Optional per-phase watchdog enabled by defining MEM_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_ctrl #(
    parameter int RAM_DATA_WIDTH = 16,
    parameter int RAM_ADDR_WIDTH = 10,
    parameter int TIMEOUT_CYCLES = 8191
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      wr_i,
    input  logic [RAM_ADDR_WIDTH-1:0] addr_i,
    input  logic [RAM_DATA_WIDTH-1:0] wdata_i,
    output logic                      ready_o,
    output logic                      done_o,
    output logic [RAM_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      mem_wr_o,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] mem_data_o,
    input  logic                      busy_mem_i,
    input  logic [RAM_DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t state_q, state_d;
    logic   timeout_hit;

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             timeout_exit;

    // Counter restarts on every state change, so each wait phase gets its own budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q != state_d) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit  = (cnt_q == CNT_LAST);
    assign timeout_exit = timeout_hit &&
                          ((state_q == WAIT_BUSY && !busy_mem_i) ||
                           (state_q == WAIT_DONE &&  busy_mem_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_exit;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_i) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy_mem_i)       state_d = WAIT_DONE;
                else if (timeout_hit) state_d = RESP;
            end
            WAIT_DONE: begin
                if (!busy_mem_i)      state_d = RESP;
                else if (timeout_hit) state_d = RESP;
            end
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory-side command is captured once and held until the response cycle has passed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            rdata_o    <= '0;
        end else begin
            if (state_q == IDLE && req_i) begin
                mem_wr_o   <= wr_i;
                mem_addr_o <= addr_i;
                mem_data_o <= wdata_i;
            end
            if (state_q == RESP) begin
                mem_wr_o <= 1'b0;
            end
            if (state_q == WAIT_DONE && !busy_mem_i && !mem_wr_o) begin
                rdata_o <= mem_data_i;
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign done_o  = (state_q == RESP);

endmodule
